pipelined_unified_memory: RTL and testbench

PIPELINED_UNIFIED_MEMORY -- requirements
Module: pipelined_unified_memory

---
 rtl/pipelined_unified_memory_if.sv | 36 +++
 rtl/pipelined_unified_memory.sv | 196 +++++++++++++++++++
 tb/tb_pipelined_unified_memory.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_unified_memory_if.sv
// Fetch and data port bundle of the unified memory.
// The memory is the slave. The core or bench is the master.
interface pipelined_unified_memory_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_rsp_valid;
    logic [31:0]           i_rsp_instr;
    logic                  i_rsp_fault;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [2:0]            d_funct3;
    logic [31:0]           d_wdata;
    logic                  d_rsp_valid;
    logic [31:0]           d_rsp_rdata;
    logic                  d_rsp_fault;

    modport master (
        output i_req_valid, i_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_instr, i_rsp_fault,
        output d_req_valid, d_req_we, d_addr, d_funct3, d_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_fault
    );

    modport slave (
        input  i_req_valid, i_addr,
        output i_req_ready, i_rsp_valid, i_rsp_instr, i_rsp_fault,
        input  d_req_valid, d_req_we, d_addr, d_funct3, d_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_fault
    );
endinterface

// File: rtl/pipelined_unified_memory.sv
// Unified instruction/data memory with a fixed-latency fetch port and a fixed-latency load/store port.
// Reads sample the array before a store on the same edge. Responses leave through a RD_LATENCY-deep pipeline.
module pipelined_unified_memory #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 2097152,
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_unified_memory_if.slave bus
);
    localparam int WORDS = MEM_SIZE / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AX    = ADDR_WIDTH + 1;
    localparam logic [AX-1:0] MEM_SIZE_X = AX'(MEM_SIZE);
    localparam logic [31:0]   NOP        = 32'h0000_0013;

    if (MEM_SIZE % 4 != 0 || MEM_SIZE < 4) begin : g_bad_size
        $error("MEM_SIZE must be a positive multiple of 4");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("RD_LATENCY must be in 1..4");
    end

    logic r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ready <= 1'b0;
        else        r_ready <= 1'b1;
    end

    assign bus.i_req_ready = r_ready;
    assign bus.d_req_ready = r_ready;

    // Fetch decode. The extra address bit keeps addr+3 from wrapping back into range.
    logic             w_i_acc;
    logic             w_i_fault;
    logic [AX-1:0]    w_i_addr_x;
    logic [IDX_W-1:0] w_i_idx;

    assign w_i_acc    = bus.i_req_valid && r_ready;
    assign w_i_addr_x = {1'b0, bus.i_addr};
    assign w_i_fault  = (bus.i_addr[1:0] != 2'b00) || (w_i_addr_x > MEM_SIZE_X - AX'(4));
    assign w_i_idx    = w_i_fault ? '0 : bus.i_addr[IDX_W+1:2];

    logic             w_d_acc;
    logic             w_d_fault;
    logic             w_d_f3_ok;
    logic             w_d_misal;
    logic [1:0]       w_d_span;
    logic [AX-1:0]    w_d_last;
    logic [3:0]       w_d_be;
    logic [31:0]      w_d_wlane;
    logic             w_d_wr;
    logic [IDX_W-1:0] w_d_idx;

    always_comb begin
        w_d_span  = 2'd3;
        w_d_be    = 4'b1111;
        w_d_wlane = bus.d_wdata;
        w_d_misal = 1'b0;
        case (bus.d_funct3[1:0])
            2'b00: begin
                w_d_span  = 2'd0;
                w_d_be    = 4'b0001 << bus.d_addr[1:0];
                w_d_wlane = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                w_d_span  = 2'd1;
                w_d_be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                w_d_wlane = {2{bus.d_wdata[15:0]}};
                w_d_misal = bus.d_addr[0];
            end
            default: w_d_misal = (bus.d_addr[1:0] != 2'b00);
        endcase
        if (bus.d_req_we)
            w_d_f3_ok = (bus.d_funct3 == 3'b000) || (bus.d_funct3 == 3'b001) || (bus.d_funct3 == 3'b010);
        else
            w_d_f3_ok = (bus.d_funct3 != 3'b011) && (bus.d_funct3 != 3'b110) && (bus.d_funct3 != 3'b111);
        w_d_last  = {1'b0, bus.d_addr} + AX'(w_d_span);
        w_d_fault = !w_d_f3_ok || w_d_misal || (w_d_last >= MEM_SIZE_X);
        w_d_acc   = bus.d_req_valid && r_ready;
        w_d_wr    = w_d_acc && bus.d_req_we && !w_d_fault;
        w_d_idx   = w_d_fault ? '0 : bus.d_addr[IDX_W+1:2];
    end

    logic [31:0] r_mem [WORDS] = '{default: NOP};
    logic [31:0] r_i_raw;
    logic [31:0] r_d_raw;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_d_wr && w_d_be[b]) r_mem[w_d_idx][8*b +: 8] <= w_d_wlane[8*b +: 8];
        end
        r_i_raw <= r_mem[w_i_idx];
        r_d_raw <= r_mem[w_d_idx];
    end

    // First pipeline stage. It holds the raw word and the request metadata needed to shape the response.
    logic       r_i_vld0;
    logic       r_d_vld0;
    logic       r_i_fault0;
    logic       r_d_fault0;
    logic       r_d_zero0;
    logic [1:0] r_d_off0;
    logic [2:0] r_d_f3_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_vld0 <= 1'b0;
            r_d_vld0 <= 1'b0;
        end else begin
            r_i_vld0 <= w_i_acc;
            r_d_vld0 <= w_d_acc;
        end
    end

    always_ff @(posedge clk) begin
        r_i_fault0 <= w_i_fault;
        r_d_fault0 <= w_d_fault;
        r_d_zero0  <= w_d_fault || bus.d_req_we;
        r_d_off0   <= bus.d_addr[1:0];
        r_d_f3_0   <= bus.d_funct3;
    end

    logic [31:0] w_d_shift;
    logic [31:0] w_d_ext;

    always_comb begin
        w_d_shift = r_d_raw >> {r_d_off0, 3'b000};
        case (r_d_f3_0)
            3'b000:  w_d_ext = {{24{w_d_shift[7]}}, w_d_shift[7:0]};
            3'b100:  w_d_ext = {24'h0, w_d_shift[7:0]};
            3'b001:  w_d_ext = {{16{w_d_shift[15]}}, w_d_shift[15:0]};
            3'b101:  w_d_ext = {16'h0, w_d_shift[15:0]};
            default: w_d_ext = w_d_shift;
        endcase
        if (r_d_zero0) w_d_ext = 32'h0;
    end

    logic        w_i_vld_s  [RD_LATENCY];
    logic [31:0] w_i_data_s [RD_LATENCY];
    logic        w_i_flt_s  [RD_LATENCY];
    logic        w_d_vld_s  [RD_LATENCY];
    logic [31:0] w_d_data_s [RD_LATENCY];
    logic        w_d_flt_s  [RD_LATENCY];

    assign w_i_vld_s[0]  = r_i_vld0;
    assign w_i_data_s[0] = r_i_fault0 ? NOP : r_i_raw;
    assign w_i_flt_s[0]  = r_i_fault0;
    assign w_d_vld_s[0]  = r_d_vld0;
    assign w_d_data_s[0] = w_d_ext;
    assign w_d_flt_s[0]  = r_d_fault0;

    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
        logic        r_i_vld;
        logic        r_d_vld;
        logic [31:0] r_i_data;
        logic [31:0] r_d_data;
        logic        r_i_flt;
        logic        r_d_flt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_i_vld <= 1'b0;
                r_d_vld <= 1'b0;
            end else begin
                r_i_vld <= w_i_vld_s[gi-1];
                r_d_vld <= w_d_vld_s[gi-1];
            end
        end

        always_ff @(posedge clk) begin
            r_i_data <= w_i_data_s[gi-1];
            r_i_flt  <= w_i_flt_s[gi-1];
            r_d_data <= w_d_data_s[gi-1];
            r_d_flt  <= w_d_flt_s[gi-1];
        end

        assign w_i_vld_s[gi]  = r_i_vld;
        assign w_i_data_s[gi] = r_i_data;
        assign w_i_flt_s[gi]  = r_i_flt;
        assign w_d_vld_s[gi]  = r_d_vld;
        assign w_d_data_s[gi] = r_d_data;
        assign w_d_flt_s[gi]  = r_d_flt;
    end

    // The valid bits reset asynchronously. They gate the payload, which therefore needs no reset.
    assign bus.i_rsp_valid = w_i_vld_s[RD_LATENCY-1];
    assign bus.i_rsp_instr = w_i_vld_s[RD_LATENCY-1] ? w_i_data_s[RD_LATENCY-1] : 32'h0;
    assign bus.i_rsp_fault = w_i_vld_s[RD_LATENCY-1] && w_i_flt_s[RD_LATENCY-1];
    assign bus.d_rsp_valid = w_d_vld_s[RD_LATENCY-1];
    assign bus.d_rsp_rdata = w_d_vld_s[RD_LATENCY-1] ? w_d_data_s[RD_LATENCY-1] : 32'h0;
    assign bus.d_rsp_fault = w_d_vld_s[RD_LATENCY-1] && w_d_flt_s[RD_LATENCY-1];

endmodule

// File: tb/tb_pipelined_unified_memory.sv
// Directed bench for pipelined_unified_memory. u_dut1 has RD_LATENCY=1 and u_dut3 has RD_LATENCY=3.
// Both instances use a 4 KiB array.
module tb_pipelined_unified_memory;
    localparam int MEM = 4096;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        f;
    } vec_t;

    // Entries 0-11 exercise faults and boundaries. Entries 12-16 exercise sub-word store lanes.
    localparam vec_t DVEC [17] = '{
        '{1'b0, 3'b010, 32'h102,      32'h0,        32'h0,        1'b1},
        '{1'b1, 3'b001, 32'h101,      32'hAAAA,     32'h0,        1'b1},
        '{1'b0, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 1'b0},
        '{1'b0, 3'b010, 32'd4094,     32'h0,        32'h0,        1'b1},
        '{1'b0, 3'b010, 32'd4096,     32'h0,        32'h0,        1'b1},
        '{1'b0, 3'b101, 32'd4094,     32'h0,        32'h0,        1'b0},
        '{1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1},
        '{1'b0, 3'b011, 32'h100,      32'h0,        32'h0,        1'b1},
        '{1'b1, 3'b100, 32'h100,      32'h11,       32'h0,        1'b1},
        '{1'b1, 3'b010, 32'd4096,     32'h11,       32'h0,        1'b1},
        '{1'b0, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 1'b0},
        '{1'b0, 3'b000, 32'd4092,     32'h0,        32'h13,       1'b0},
        '{1'b1, 3'b000, 32'h104,      32'h123456AB, 32'h0,        1'b0},
        '{1'b1, 3'b001, 32'h106,      32'h1234CAFE, 32'h0,        1'b0},
        '{1'b0, 3'b010, 32'h104,      32'h0,        32'hCAFE00AB, 1'b0},
        '{1'b0, 3'b001, 32'h106,      32'h0,        32'hFFFFCAFE, 1'b0},
        '{1'b0, 3'b100, 32'h105,      32'h0,        32'h0,        1'b0}
    };

    localparam logic [2:0]  LD_F3   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    localparam logic [31:0] LD_ADDR [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    localparam logic [31:0] LD_EXP  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    localparam logic [31:0] FE_ADDR [5] = '{32'h0, 32'h2, 32'd4092, 32'd4096, 32'hFFFFFFFC};
    localparam logic        FE_FLT  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] B2B_VAL [4] = '{32'hC0DE0000, 32'hC0DE1111, 32'hC0DE2222, 32'hC0DE3333};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipelined_unified_memory_if #(.ADDR_WIDTH(32)) bus1 ();
    pipelined_unified_memory_if #(.ADDR_WIDTH(32)) bus3 ();

    pipelined_unified_memory #(.ADDR_WIDTH(32), .MEM_SIZE(MEM), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    pipelined_unified_memory #(.ADDR_WIDTH(32), .MEM_SIZE(MEM), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    // One request cycle on u_dut1. Its response arrives right after the accept edge.
    task automatic txn1(input logic iv, input logic [31:0] ia, input logic dv, input logic we,
                        input logic [2:0] f3, input logic [31:0] da, input logic [31:0] wd,
                        output logic ov_i, output logic [31:0] o_ins, output logic of_i,
                        output logic ov_d, output logic [31:0] o_rd, output logic of_d);
        @(negedge clk);
        bus1.i_req_valid = iv;
        bus1.i_addr      = ia;
        bus1.d_req_valid = dv;
        bus1.d_req_we    = we;
        bus1.d_funct3    = f3;
        bus1.d_addr      = da;
        bus1.d_wdata     = wd;
        @(posedge clk);
        #1;
        ov_i  = bus1.i_rsp_valid;
        o_ins = bus1.i_rsp_instr;
        of_i  = bus1.i_rsp_fault;
        ov_d  = bus1.d_rsp_valid;
        o_rd  = bus1.d_rsp_rdata;
        of_d  = bus1.d_rsp_fault;
        bus1.i_req_valid = 1'b0;
        bus1.d_req_valid = 1'b0;
        $display("txn1 fetch(v=%b a=%h) -> v=%b ins=%h f=%b | data(v=%b we=%b f3=%b a=%h wd=%h) -> v=%b rd=%h f=%b",
                 iv, ia, ov_i, o_ins, of_i, dv, we, f3, da, wd, ov_d, o_rd, of_d);
    endtask

    task automatic test_reset();
        {bus1.i_req_valid, bus1.d_req_valid, bus1.d_req_we, bus3.i_req_valid, bus3.d_req_valid, bus3.d_req_we} = '0;
        bus1.i_addr = '0; bus1.d_addr = '0; bus1.d_funct3 = '0; bus1.d_wdata = '0;
        bus3.i_addr = '0; bus3.d_addr = '0; bus3.d_funct3 = '0; bus3.d_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus1.i_req_ready, bus1.d_req_ready, bus1.i_rsp_valid, bus1.d_rsp_valid, bus1.i_rsp_instr, bus1.d_rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_u1: rdy=%b%b vld=%b%b ins=%h rd=%h required all zero",
                     bus1.i_req_ready, bus1.d_req_ready, bus1.i_rsp_valid, bus1.d_rsp_valid, bus1.i_rsp_instr, bus1.d_rsp_rdata);
        end
        checks++;
        if ({bus3.i_req_ready, bus3.d_req_ready, bus3.i_rsp_valid, bus3.d_rsp_valid, bus3.i_rsp_fault, bus3.d_rsp_fault} !== '0) begin
            errors++;
            $display("FAIL reset_u3: rdy=%b%b vld=%b%b flt=%b%b required all zero",
                     bus3.i_req_ready, bus3.d_req_ready, bus3.i_rsp_valid, bus3.d_rsp_valid, bus3.i_rsp_fault, bus3.d_rsp_fault);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus1.i_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", bus1.i_req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus1.i_req_ready, bus1.d_req_ready, bus3.i_req_ready, bus3.d_req_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL ready_after_edge: got %b%b%b%b required 1111",
                     bus1.i_req_ready, bus1.d_req_ready, bus3.i_req_ready, bus3.d_req_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_fetch();
        logic iv, ifl, dv, df;
        logic [31:0] ins, rd;
        for (int k = 0; k < 5; k++) begin
            txn1(1'b1, FE_ADDR[k], 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, iv, ins, ifl, dv, rd, df);
            checks++;
            if (iv !== 1'b1 || ins !== 32'h13 || ifl !== FE_FLT[k] || dv !== 1'b0) begin
                errors++;
                $display("FAIL fetch_%0d: v=%b ins=%h f=%b dv=%b required 1/00000013/%b/0", k, iv, ins, ifl, dv, FE_FLT[k]);
            end
        end
    endtask

    task automatic test_loads();
        logic iv, ifl, dv, df;
        logic [31:0] ins, rd;
        txn1(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, iv, ins, ifl, dv, rd, df);
        checks++;
        if (dv !== 1'b1 || rd !== 32'h0 || df !== 1'b0 || iv !== 1'b0) begin
            errors++;
            $display("FAIL sw_rsp: v=%b rd=%h f=%b iv=%b required 1/00000000/0/0", dv, rd, df, iv);
        end
        for (int k = 0; k < 4; k++) begin
            txn1(1'b0, 32'h0, 1'b1, 1'b0, LD_F3[k], LD_ADDR[k], 32'h0, iv, ins, ifl, dv, rd, df);
            checks++;
            if (dv !== 1'b1 || rd !== LD_EXP[k] || df !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d: v=%b rd=%h f=%b required 1/%h/0", k, dv, rd, df, LD_EXP[k]);
            end
        end
    endtask

    task automatic run_dvec(input int lo, input int hi);
        logic iv, ifl, dv, df;
        logic [31:0] ins, rd;
        for (int k = lo; k <= hi; k++) begin
            txn1(1'b0, 32'h0, 1'b1, DVEC[k].we, DVEC[k].f3, DVEC[k].a, DVEC[k].wd, iv, ins, ifl, dv, rd, df);
            checks++;
            if (dv !== 1'b1 || rd !== DVEC[k].rd || df !== DVEC[k].f) begin
                errors++;
                $display("FAIL dvec_%0d: v=%b rd=%h f=%b required 1/%h/%b", k, dv, rd, df, DVEC[k].rd, DVEC[k].f);
            end
        end
    endtask

    task automatic test_faults();
        run_dvec(0, 11);
    endtask

    task automatic test_store_lanes();
        run_dvec(12, 16);
    endtask

    task automatic test_read_before_write();
        logic iv, ifl, dv, df;
        logic [31:0] ins, rd;
        txn1(1'b1, 32'h200, 1'b1, 1'b1, 3'b010, 32'h200, 32'h12345678, iv, ins, ifl, dv, rd, df);
        checks++;
        if (iv !== 1'b1 || ins !== 32'h13 || ifl !== 1'b0 || dv !== 1'b1 || df !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_fetch: iv=%b ins=%h f=%b dv=%b df=%b required 1/00000013/0/1/0", iv, ins, ifl, dv, df);
        end
        txn1(1'b1, 32'h200, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, iv, ins, ifl, dv, rd, df);
        checks++;
        if (iv !== 1'b1 || ins !== 32'h12345678 || ifl !== 1'b0) begin
            errors++;
            $display("FAIL next_fetch: v=%b ins=%h f=%b required 1/12345678/0", iv, ins, ifl);
        end
        txn1(1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h300, 32'hA5A50F0F, iv, ins, ifl, dv, rd, df);
        txn1(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, iv, ins, ifl, dv, rd, df);
        checks++;
        if (dv !== 1'b1 || rd !== 32'hA5A50F0F || df !== 1'b0) begin
            errors++;
            $display("FAIL load_after_store: v=%b rd=%h f=%b required 1/a5a50f0f/0", dv, rd, df);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_d;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus3.d_req_valid = 1'b1; bus3.d_req_we = 1'b1; bus3.d_funct3 = 3'b010;
            bus3.d_addr = 32'h40 + 32'(4 * k); bus3.d_wdata = B2B_VAL[k];
            @(posedge clk);
        end
        @(negedge clk);
        bus3.d_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus3.d_req_valid = (c < 4); bus3.d_req_we = 1'b0; bus3.d_funct3 = 3'b010;
            bus3.i_req_valid = (c < 4);
            bus3.d_addr = 32'h40 + 32'(4 * c);
            bus3.i_addr = 32'h40 + 32'(4 * c);
            @(posedge clk);
            #1;
            exp_v = (c >= 2 && c <= 5);
            exp_d = exp_v ? B2B_VAL[(c + 2) % 4] : 32'h0;
            $display("b2b cycle %0d: d v=%b rd=%h | i v=%b ins=%h", c, bus3.d_rsp_valid, bus3.d_rsp_rdata,
                     bus3.i_rsp_valid, bus3.i_rsp_instr);
            checks++;
            if (bus3.d_rsp_valid !== exp_v || bus3.d_rsp_rdata !== exp_d || bus3.d_rsp_fault !== 1'b0) begin
                errors++;
                $display("FAIL b2b_load_c%0d: v=%b rd=%h f=%b required %b/%h/0", c, bus3.d_rsp_valid,
                         bus3.d_rsp_rdata, bus3.d_rsp_fault, exp_v, exp_d);
            end
            checks++;
            if (bus3.i_rsp_valid !== exp_v || bus3.i_rsp_instr !== exp_d) begin
                errors++;
                $display("FAIL b2b_fetch_c%0d: v=%b ins=%h required %b/%h", c, bus3.i_rsp_valid,
                         bus3.i_rsp_instr, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic iv, ifl, dv, df;
        logic [31:0] ins, rd;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus3.d_req_valid = 1'b1; bus3.d_req_we = 1'b0; bus3.d_funct3 = 3'b010;
            bus3.d_addr = 32'h40 + 32'(4 * c);
            @(posedge clk);
        end
        #1;
        checks++;
        if (bus3.d_rsp_valid !== 1'b1 || bus3.d_rsp_rdata !== B2B_VAL[0]) begin
            errors++;
            $display("FAIL inflight_first: v=%b rd=%h required 1/%h", bus3.d_rsp_valid, bus3.d_rsp_rdata, B2B_VAL[0]);
        end
        #1;
        rst_n = 1'b0;
        bus3.d_req_valid = 1'b0;
        bus1.d_req_valid = 1'b1; bus1.d_req_we = 1'b1; bus1.d_funct3 = 3'b010;
        bus1.d_addr = 32'h400; bus1.d_wdata = 32'h55555555;
        #1;
        checks++;
        if ({bus3.d_rsp_valid, bus3.d_req_ready, bus3.i_req_ready} !== 3'b000 || bus3.d_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_at_once: v=%b rdy=%b%b rd=%h required 0/00/00000000",
                     bus3.d_rsp_valid, bus3.d_req_ready, bus3.i_req_ready, bus3.d_rsp_rdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus1.d_req_valid = 1'b0;
        #1;
        checks++;
        if (bus3.d_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release: got %b required 0", bus3.d_req_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus3.d_rsp_valid !== 1'b0 || bus3.d_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_c%0d: v=%b rdy=%b required 0/1", c, bus3.d_rsp_valid, bus3.d_req_ready);
            end
        end
        txn1(1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, iv, ins, ifl, dv, rd, df);
        checks++;
        if (dv !== 1'b1 || rd !== 32'h13 || df !== 1'b0) begin
            errors++;
            $display("FAIL no_store_in_reset: v=%b rd=%h f=%b required 1/00000013/0", dv, rd, df);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_faults();
        test_store_lanes();
        test_read_before_write();
        test_back_to_back();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
